// File: rtl/debug_display_slave.sv
// Avalon-MM debug display slave: hex-encodes a 24-bit value onto six active-low
// seven-segment digits and drives an LED word. Optional digit blink: DEBUG_DISPLAY_BLINK_EN.
module debug_display_slave #(
  parameter int unsigned BLINK_DIV = 25000000,
  parameter logic [9:0]  LED_RESET = 10'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic [41:0] debug_seg_conduit,
  output logic [9:0]  debug_light_conduit
);

  typedef enum logic [1:0] {
    ADDR_VALUE  = 2'd0,
    ADDR_LEDS   = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_WCOUNT = 2'd3
  } reg_addr_e;

  logic [23:0] value_q, value_d;
  logic [9:0]  leds_q, leds_d;
  logic [5:0]  en_q, en_d;
  logic        lzb_q, lzb_d;
  logic [15:0] wcount_q, wcount_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [41:0] seg_q, seg_d;
  logic [9:0]  light_q, light_d;

  logic [31:0] rd_mux;
  logic [5:0]  blink_mask;
  logic [5:0]  blink_off;
  logic [5:0]  lz_blank;
  logic        zero_run;
  logic        unused_wdata;

  // Out-of-range divider shows up as this named block in the elaborated hierarchy.
  if (BLINK_DIV < 2) begin : g_blink_div_too_small
  end

`ifdef DEBUG_DISPLAY_BLINK_EN
  logic [5:0]  blink_q, blink_d;
  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (cnt_q == 32'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      blink_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    blink_d = blink_q;
    if (write && (address == ADDR_CTRL)) blink_d = writedata[13:8];
  end

  assign blink_mask = blink_q;
  assign blink_off  = blink_q & {6{phase_q}};
`else
  assign blink_mask = '0;
  assign blink_off  = '0;
`endif

  assign unused_wdata = ^writedata[31:24];

  always_comb begin
    rd_mux = '0;
    case (reg_addr_e'(address))
      ADDR_VALUE:  rd_mux = {8'h00, value_q};
      ADDR_LEDS:   rd_mux = {22'h0, leds_q};
      ADDR_CTRL:   rd_mux = {18'h0, blink_mask, 1'b0, lzb_q, en_q};
      ADDR_WCOUNT: rd_mux = {16'h0, wcount_q};
      default:     rd_mux = '0;
    endcase
  end

  // A write wins over a simultaneous read; the read is dropped with no valid pulse.
  always_comb begin
    value_d  = value_q;
    leds_d   = leds_q;
    en_d     = en_q;
    lzb_d    = lzb_q;
    wcount_d = wcount_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (write) begin
      case (reg_addr_e'(address))
        ADDR_VALUE: begin
          value_d  = writedata[23:0];
          wcount_d = wcount_q + 16'd1;
        end
        ADDR_LEDS:   leds_d = writedata[9:0];
        ADDR_CTRL: begin
          en_d  = writedata[5:0];
          lzb_d = writedata[6];
        end
        ADDR_WCOUNT: wcount_d = '0;
        default: ;
      endcase
    end else if (read) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
    end
  end

  // Scan from HEX5 down to HEX1; HEX0 always shows its digit.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      if (value_q[4*(5-k) +: 4] != 4'h0) zero_run = 1'b0;
      lz_blank[5-k] = zero_run & lzb_q;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_comb begin
    seg_d   = '1;
    light_d = leds_q;
    for (int unsigned i = 0; i < 6; i++) begin
      if (!en_q[i] || lz_blank[i] || blink_off[i]) seg_d[41-7*i -: 7] = 7'h7F;
      else seg_d[41-7*i -: 7] = hex7(value_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q  <= '0;
      leds_q   <= LED_RESET;
      en_q     <= 6'h3F;
      lzb_q    <= 1'b0;
      wcount_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      seg_q    <= '1;
      light_q  <= '0;
    end else begin
      value_q  <= value_d;
      leds_q   <= leds_d;
      en_q     <= en_d;
      lzb_q    <= lzb_d;
      wcount_q <= wcount_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      seg_q    <= seg_d;
      light_q  <= light_d;
    end
  end

  assign readdata            = rdata_q;
  assign readdatavalid       = rvalid_q;
  assign debug_seg_conduit   = seg_q;
  assign debug_light_conduit = light_q;

endmodule
